fec_codec: RTL and testbench



---
 rtl/fec_codec_if.sv | 29 ++
 rtl/fec_codec.sv | 101 ++++++++++
 tb/tb_fec_codec.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fec_codec_if.sv
// Symbol/coefficient bus of the cyclic-ring FEC codec: request side from the
// symbol buffer, all stage results back to the payload sink.
interface fec_codec_if #(
    parameter int M     = 3,
    parameter int WIDTH = 11
);
    localparam int DATA_W = WIDTH - 1;

    logic              in_valid;
    logic [DATA_W-1:0] symbols_in      [M];
    logic [WIDTH-1:0]  decode_coeffs   [M][M];
    logic [WIDTH-1:0]  encode_coeffs   [M][M];

    logic              out_valid;
    logic [DATA_W-1:0] symbols_out     [M];
    logic [WIDTH-1:0]  lifted_symbols  [M];
    logic [WIDTH-1:0]  decoded_symbols [M];
    logic [WIDTH-1:0]  encoded_symbols [M];

    modport master (
        output in_valid, symbols_in, decode_coeffs, encode_coeffs,
        input  out_valid, symbols_out, lifted_symbols, decoded_symbols, encoded_symbols
    );

    modport slave (
        input  in_valid, symbols_in, decode_coeffs, encode_coeffs,
        output out_valid, symbols_out, lifted_symbols, decoded_symbols, encoded_symbols
    );
endinterface

// File: rtl/fec_codec.sv
// Cyclic-shift network-coding codec: lift into GF(2)[x]/(x^WIDTH+1), apply a
// decode then an encode coefficient matrix, project back; one register stage.
module fec_row #(
    parameter int M     = 3,
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] coeffs [M],
    input  logic [WIDTH-1:0] vec    [M],
    output logic [WIDTH-1:0] acc
);
    // Cyclic convolution: each set coefficient bit k adds b rotated left by k.
    // For k=0 the right shift is by WIDTH and contributes nothing.
    function automatic logic [WIDTH-1:0] ring_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < WIDTH; k++)
            if (a[k]) r ^= (b << k) | (b >> (WIDTH - k));
        return r;
    endfunction

    always_comb begin
        acc = '0;
        for (int j = 0; j < M; j++)
            acc ^= ring_mul(coeffs[j], vec[j]);
    end
endmodule

module fec_codec #(
    parameter int M     = 3,
    parameter int WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    fec_codec_if.slave  bus
);
    localparam int DATA_W = WIDTH - 1;

    logic [WIDTH-1:0]  lifted    [M];
    logic [WIDTH-1:0]  decoded   [M];
    logic [WIDTH-1:0]  encoded   [M];
    logic [DATA_W-1:0] projected [M];

    logic              vld_q;
    logic [WIDTH-1:0]  lifted_q  [M];
    logic [WIDTH-1:0]  decoded_q [M];
    logic [WIDTH-1:0]  encoded_q [M];
    logic [DATA_W-1:0] symbols_q [M];

    genvar g;
    generate
        for (g = 0; g < M; g++) begin : g_row
            assign lifted[g] = {1'b0, bus.symbols_in[g]};

            fec_row #(.M(M), .WIDTH(WIDTH)) u_dec (
                .coeffs (bus.decode_coeffs[g]),
                .vec    (lifted),
                .acc    (decoded[g])
            );

            fec_row #(.M(M), .WIDTH(WIDTH)) u_enc (
                .coeffs (bus.encode_coeffs[g]),
                .vec    (decoded),
                .acc    (encoded[g])
            );

            // Folding the top bit into the rest reduces mod 1+x+...+x^(WIDTH-1).
            assign projected[g] = encoded[g][DATA_W-1:0] ^ {DATA_W{encoded[g][WIDTH-1]}};

            assign bus.lifted_symbols[g]  = lifted_q[g];
            assign bus.decoded_symbols[g] = decoded_q[g];
            assign bus.encoded_symbols[g] = encoded_q[g];
            assign bus.symbols_out[g]     = symbols_q[g];
        end
    endgenerate

    assign bus.out_valid = vld_q;

    // Data only loads on accepted inputs so it holds through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            for (int i = 0; i < M; i++) begin
                lifted_q[i]  <= '0;
                decoded_q[i] <= '0;
                encoded_q[i] <= '0;
                symbols_q[i] <= '0;
            end
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < M; i++) begin
                    lifted_q[i]  <= lifted[i];
                    decoded_q[i] <= decoded[i];
                    encoded_q[i] <= encoded[i];
                    symbols_q[i] <= projected[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_fec_codec.sv
// Directed-vector bench for fec_codec (M=3, WIDTH=11) with hand-computed results.
module tb_fec_codec;
    localparam int M  = 3;
    localparam int W  = 11;
    localparam int DW = W - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    fec_codec_if #(.M(M), .WIDTH(W)) bus ();

    fec_codec #(.M(M), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // stage: 0 lifted, 1 decoded, 2 encoded, 3 symbols_out
    task automatic chk_stage(input string tag, input int stage, input int e0, input int e1, input int e2);
        int e [M];
        logic [31:0] v;
        e = '{e0, e1, e2};
        for (int i = 0; i < M; i++) begin
            case (stage)
                0:       v = 32'(bus.lifted_symbols[i]);
                1:       v = 32'(bus.decoded_symbols[i]);
                2:       v = 32'(bus.encoded_symbols[i]);
                default: v = 32'(bus.symbols_out[i]);
            endcase
            chk($sformatf("%s[%0d]", tag, i), v, 32'(e[i]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 0);
        chk_stage({tag, ".lifted"},  0, 0, 0, 0);
        chk_stage({tag, ".decoded"}, 1, 0, 0, 0);
        chk_stage({tag, ".encoded"}, 2, 0, 0, 0);
        chk_stage({tag, ".out"},     3, 0, 0, 0);
    endtask

    task automatic set_ident();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                bus.decode_coeffs[i][j] = (i == j) ? W'(1) : W'(0);
                bus.encode_coeffs[i][j] = (i == j) ? W'(1) : W'(0);
            end
    endtask

    task automatic set_syms(input int s0, input int s1, input int s2);
        bus.symbols_in[0] = DW'(s0);
        bus.symbols_in[1] = DW'(s1);
        bus.symbols_in[2] = DW'(s2);
    endtask

    // Present one valid generation at negedge, then sample just after the edge.
    task automatic cycle_valid();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        int dec_t [M][M];
        int enc_t [M][M];
        dec_t = '{'{1, 511, 256}, '{0, 682, 853}, '{0, 853, 597}};
        enc_t = '{'{1, 1, 1},     '{0, 2, 4},     '{0, 4, 16}};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        set_ident();
        set_syms(0, 0, 0);
        #1;
        chk_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("post_reset_idle");
        @(negedge clk);

        // Inverse coefficient pair
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                bus.decode_coeffs[i][j] = W'(dec_t[i][j]);
                bus.encode_coeffs[i][j] = W'(enc_t[i][j]);
            end
        set_syms(753, 1000, 748);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("inv.out_valid", 32'(bus.out_valid), 1);
        chk_stage("inv.lifted",  0, 753, 1000, 748);
        chk_stage("inv.decoded", 1, 1954, 305, 1122);
        chk_stage("inv.encoded", 2, 753, 1000, 748);
        chk_stage("inv.out",     3, 753, 1000, 748);
        @(negedge clk);

        // Identity matrices
        set_ident();
        set_syms(0, 1023, 512);
        @(posedge clk);
        #1;
        chk_stage("id.decoded", 1, 0, 1023, 512);
        chk_stage("id.encoded", 2, 0, 1023, 512);
        chk_stage("id.out",     3, 0, 1023, 512);
        @(negedge clk);

        // Projection of the top bit
        bus.encode_coeffs[0][0] = W'(2);
        set_syms(512, 5, 7);
        @(posedge clk);
        #1;
        chk_stage("proj.encoded", 2, 1024, 5, 7);
        chk_stage("proj.out",     3, 1023, 5, 7);
        @(negedge clk);

        // Rotation wrapping past bit WIDTH-1
        set_ident();
        bus.decode_coeffs[0][0] = W'(1024);
        set_syms(3, 0, 0);
        @(posedge clk);
        #1;
        chk_stage("wrap.decoded", 1, 1025, 0, 0);
        chk_stage("wrap.out",     3, 1022, 0, 0);
        @(negedge clk);

        // Three back-to-back generations, then idle
        set_ident();
        set_syms(1, 2, 3);
        @(posedge clk);
        #1;
        chk("s1.out_valid", 32'(bus.out_valid), 1);
        chk_stage("s1.out", 3, 1, 2, 3);
        @(negedge clk);
        set_syms(100, 200, 300);
        @(posedge clk);
        #1;
        chk("s2.out_valid", 32'(bus.out_valid), 1);
        chk_stage("s2.out", 3, 100, 200, 300);
        @(negedge clk);
        set_syms(1023, 0, 511);
        @(posedge clk);
        #1;
        chk("s3.out_valid", 32'(bus.out_valid), 1);
        chk_stage("s3.encoded", 2, 1023, 0, 511);
        @(negedge clk);
        bus.in_valid = 1'b0;
        set_syms(9, 9, 9);
        @(posedge clk);
        #1;
        chk("idle.out_valid", 32'(bus.out_valid), 0);
        chk_stage("idle.hold", 3, 1023, 0, 511);
        chk_stage("idle.hold_lifted", 0, 1023, 0, 511);
        @(negedge clk);

        // Asynchronous reset between edges while out_valid=1
        set_syms(4, 5, 6);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst.out_valid", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        // Valid inputs during reset are ignored across an edge
        @(posedge clk);
        #1;
        chk_all_zero("in_rst");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("rst_release");
        @(negedge clk);
        set_syms(10, 20, 30);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst.out_valid", 32'(bus.out_valid), 1);
        chk_stage("after_rst.out", 3, 10, 20, 30);
        @(negedge clk);
        bus.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
